// File: rtl/rv_data_memory.sv
// Word-organised data RAM for the RV32I single-cycle core: asynchronous read, synchronous write.
// Optional macro DMEM_DEBUG_PORTS_EN adds DM0/DM4/DM8 observation outputs for words 0..2.
module rv_data_memory #(
    parameter int unsigned DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WE,
    input  logic [31:0] A,
    input  logic [31:0] WD,
`ifdef DMEM_DEBUG_PORTS_EN
    output logic [31:0] DM0,
    output logic [31:0] DM4,
    output logic [31:0] DM8,
`endif
    output logic [31:0] ReadData
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic          in_range;
    logic          unused_bits;

    assign idx         = A[AW+1:2];
    assign in_range    = (A[31:AW+2] == '0);
    assign unused_bits = &{1'b0, A[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (WE && in_range) begin
            mem[idx] <= WD;
        end
    end

    // Out-of-range addresses read as zero rather than aliasing onto the array.
    always_comb begin
        ReadData = '0;
        if (rst && in_range) begin
            ReadData = mem[idx];
        end
    end

`ifdef DMEM_DEBUG_PORTS_EN
    assign DM0 = mem[0];
    assign DM4 = mem[1];
    assign DM8 = mem[2];
`endif

endmodule

// File: tb/tb_rv_data_memory.sv
// Directed self-checking bench for rv_data_memory (default DEPTH=64).
module tb_rv_data_memory;

    logic        clk;
    logic        rst;
    logic        WE;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] ReadData;
`ifdef DMEM_DEBUG_PORTS_EN
    logic [31:0] DM0;
    logic [31:0] DM4;
    logic [31:0] DM8;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    rv_data_memory #(.DEPTH(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .WE       (WE),
        .A        (A),
        .WD       (WD),
`ifdef DMEM_DEBUG_PORTS_EN
        .DM0      (DM0),
        .DM4      (DM4),
        .DM8      (DM8),
`endif
        .ReadData (ReadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        WE = 1'b1;
        A  = addr;
        WD = data;
        @(posedge clk);
        #1;
        WE = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        A = addr;
        #1;
        check(tag, ReadData, exp);
    endtask

    initial begin
        // Reset held with a pending write that must be ignored
        rst = 1'b0;
        WE  = 1'b1;
        A   = 32'hA;
        WD  = 32'h27;
        #1;
        check("rst_rd0", ReadData, 32'h0);
        @(posedge clk); #1;
        check("rst_rd1", ReadData, 32'h0);
        @(posedge clk); #1;
        check("rst_rd2", ReadData, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        WE  = 1'b0;
        read_check("rst_nowrite", 32'h8, 32'h0);

        // Basic write, low address bits ignored
        @(negedge clk);
        WE = 1'b1;
        A  = 32'hA;
        WD = 32'h27;
        #1;
        check("wr_pre", ReadData, 32'h0);
        @(posedge clk); #1;
        WE = 1'b0;
        check("wr_A", ReadData, 32'h27);
        read_check("wr_8", 32'h8, 32'h27);
        read_check("wr_7", 32'h7, 32'h0);

        // Combinational read follows A without a clock edge
        write_word(32'h4, 32'h1111_1111);
        write_word(32'h8, 32'h2222_2222);
        @(negedge clk);
        read_check("comb_4", 32'h4, 32'h1111_1111);
        read_check("comb_8", 32'h8, 32'h2222_2222);
        read_check("comb_0", 32'h0, 32'h0);

        // Read-during-write: old data before edge, new data after
        write_word(32'hC, 32'hAAAA_AAAA);
        @(negedge clk);
        WE = 1'b1;
        A  = 32'hC;
        WD = 32'h5555_5555;
        #1;
        check("rdw_old", ReadData, 32'hAAAA_AAAA);
        @(posedge clk); #1;
        WE = 1'b0;
        check("rdw_new", ReadData, 32'h5555_5555);

        // WE held across several edges: last WD wins
        @(negedge clk);
        WE = 1'b1;
        A  = 32'h10;
        WD = 32'h0000_0001;
        @(posedge clk); #1;
        WD = 32'h0000_0002;
        @(posedge clk); #1;
        WD = 32'h0000_0003;
        @(posedge clk); #1;
        WE = 1'b0;
        read_check("hold_last", 32'h10, 32'h0000_0003);

        // Out of range: no aliasing onto word 0 (0x100 would alias with idx=0)
        write_word(32'h0, 32'h0BAD_F00D);
        write_word(32'h100, 32'hDEAD_BEEF);
        @(negedge clk);
        read_check("oor_rd", 32'h100, 32'h0);
        read_check("oor_w0", 32'h0, 32'h0BAD_F00D);
        read_check("oor_hi", 32'h8000_0004, 32'h0);

`ifdef DMEM_DEBUG_PORTS_EN
        check("dm0_pre", DM0, 32'h0BAD_F00D);
        check("dm4_pre", DM4, 32'h1111_1111);
        check("dm8_pre", DM8, 32'h2222_2222);
`endif

        // Asynchronous reset pulse between edges, with a write pending
        @(negedge clk);
        A  = 32'h4;
        #1;
        check("arst_pre", ReadData, 32'h1111_1111);
        WE  = 1'b1;
        WD  = 32'hFFFF_FFFF;
        rst = 1'b0;
        #1;
        check("arst_rd", ReadData, 32'h0);
`ifdef DMEM_DEBUG_PORTS_EN
        check("dm0_rst", DM0, 32'h0);
        check("dm4_rst", DM4, 32'h0);
        check("dm8_rst", DM8, 32'h0);
`endif
        #1;
        rst = 1'b1;
        WE  = 1'b0;
        read_check("arst_w0", 32'h0, 32'h0);
        read_check("arst_w1", 32'h4, 32'h0);
        read_check("arst_w2", 32'h8, 32'h0);
        read_check("arst_w3", 32'hC, 32'h0);
        read_check("arst_w4", 32'h10, 32'h0);

        // Top word of the array still in range
        write_word(32'hFC, 32'h1234_5678);
        @(negedge clk);
        read_check("top_word", 32'hFF, 32'h1234_5678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_data_memory.md
Name: rv_data_memory

Overview:
- Word-organised data RAM for the RV32I single-cycle core, sitting after the ALU in the load/store path.
- Combinational (asynchronous) read, synchronous write on the rising clock edge.
- Asynchronous active-low reset clears the entire array.
- The address is a byte address from the ALU; the low two bits are ignored, so every access is a full aligned 32-bit word.

Parameters:
- DEPTH, 64, number of 32-bit words stored; must be a power of two, minimum 4.
- AW, log2(DEPTH) (derived, 6 by default), width of the word index taken from A.

Ports:
- clk  input  1  system clock; writes occur on its rising edge.
- rst  input  1  asynchronous, active-low reset; clears the memory.
- WE  input  1  write enable, active-high, sampled on the rising edge of clk.
- A  input  32  byte address; word index = A[AW+1:2].
- WD  input  32  write data.
- ReadData  output  32  combinational read data for the word selected by A.

Behaviour:
- Reset is asynchronous and active-low. The port is named rst as in the codebase.
  - While rst=0, every word is 0 and ReadData is 0, independent of clk.
  - Writes are ignored while rst=0.
  - Reset may be asserted at any time, including mid-cycle while WE=1; it overrides the pending write.
- Addressing:
  - idx = A[AW+1:2]. A[1:0] are ignored, so A=0xA and A=0x8 both select word 2.
  - If any of A[31:AW+2] is nonzero, the address is out of range: reads return 0 and writes are dropped. There is no wrap-around and no aliasing.
- Write:
  - On posedge clk with rst=1, WE=1 and an in-range address, mem[idx] <= WD (all 32 bits).
  - With WE=0, memory holds its contents.
- Read:
  - ReadData = mem[idx], purely combinational with zero-cycle latency.
  - It follows changes on A within the same cycle.
- Read-during-write to the same address:
  - Before the edge, ReadData shows the old contents.
  - After the edge, it shows WD.
  - There is no write-first bypass.
- Repeated writes with WE held high across several edges rewrite the same word each cycle; the last WD wins.
- Power-up contents are not relied upon. Reset must be applied before use.

Optional Feature:
- Macro DMEM_DEBUG_PORTS_EN.
- When defined: three extra outputs are added, DM0, DM4 and DM8, each 32 bits.
  - They continuously expose mem[0], mem[1] and mem[2], i.e. byte addresses 0x0, 0x4 and 0x8.
  - They are 0 during reset.
  - They are intended for waveform and bench observation.
- When undefined: these ports do not exist and the functional behaviour is otherwise identical.

Test Plan:
1. Drive rst=0 for 2 cycles with WE=1, A=0xA, WD=0x27.
   -> ReadData=0 throughout. After rst=1 with WE=0, a read at A=0x8 returns 0, so the write was ignored.
2. With rst=1, WE=1, A=0xA, WD=0x27, apply one edge, then WE=0.
   -> ReadData=0x27 at A=0xA and at A=0x8. A=0x7 (word 1) returns 0.
3. Write 0x1111_1111 to A=0x4 and 0x2222_2222 to A=0x8, then hold WE=0 and switch A between 0x4, 0x8 and 0x0 without a clock edge.
   -> ReadData changes immediately to 0x11111111, 0x22222222 and 0 respectively.
4. Preload word 3 with 0xAAAA_AAAA. Set WE=1, A=0xC, WD=0x5555_5555.
   -> ReadData=0xAAAAAAAA before the edge and 0x55555555 after it.
5. Out-of-range access: A = 0x100 (DEPTH=64), WE=1, WD=0xDEAD_BEEF, one edge.
   -> ReadData=0 at 0x100, and word 0 (A=0x0) is unchanged.
6. Fill words 0–2 with nonzero data, then pulse rst=0 asynchronously between clock edges.
   -> ReadData is 0 immediately and all words are 0 after release. With DMEM_DEBUG_PORTS_EN, DM0, DM4 and DM8 go from the written values to 0.
